fsm_actuator: RTL
=================

Name: fsm_actuator

Overview:
- Responder at the far end of the fsm_module command interface.
- Consumes EN_INSERT / EN_RELEASE / EN_RESET / EN_ALARM and drives a stepped motor model with a position counter.
- Returns FAULT to the controller, plus motion status (BUSY, DONE, POS) and alarm outputs.
- Sits between the control FSM and the mechanism; closes the loop on the controller's FAULT input.

Parameters:
POS_W, 4, width of position counter
POS_MAX, 10, fully-inserted position (must be < 2^POS_W)
STEP_CYCLES, 4, clock cycles per position step while moving (>=1)
TIMEOUT, 16, consecutive stalled cycles before fault (>=1)
ALARM_DIV, 2, BUZZ toggle period in cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
EN_INSERT  input  1  command: move toward POS_MAX
EN_RELEASE  input  1  command: move toward 0
EN_RESET  input  1  command: clear fault/alarm, home to 0
EN_ALARM  input  1  command: emergency stop + alarm
JAM  input  1  mechanism stall indicator (blocks stepping)
MOTOR_ON  output  1  motor drive enable
MOTOR_DIR  output  1  1 = insert direction, 0 = release/home
POS  output  POS_W  current position
BUSY  output  1  high in MOVE_IN, MOVE_OUT, HOMING
DONE  output  1  one-cycle completion pulse
FAULT  output  1  latched fault, to controller FAULT input
ALARM_OUT  output  1  alarm active level
BUZZ  output  1  alarm tone, toggles every ALARM_DIV cycles in ALARM

Behaviour:
- Interface decisions: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge, any state, including mid-move):
  - State = IDLE; POS = 0.
  - Step and stall counters = 0.
  - All outputs = 0.
- States: IDLE, MOVE_IN, MOVE_OUT, HOMING, FAULTED, ALARM. All outputs are registered.
- IDLE: commands are sampled at each edge; priority is ALARM > RESET > (INSERT & RELEASE) > INSERT > RELEASE.
  - EN_ALARM -> ALARM.
  - EN_RESET -> HOMING; if POS==0, go straight to IDLE with a DONE pulse.
  - EN_INSERT & EN_RELEASE together -> FAULTED (illegal command).
  - EN_INSERT: if POS==POS_MAX, DONE pulse and stay IDLE; else -> MOVE_IN.
  - EN_RELEASE: if POS==0, DONE pulse and stay IDLE; else -> MOVE_OUT.
- Motion states (MOVE_IN, MOVE_OUT, HOMING):
  - MOTOR_ON=1. MOTOR_DIR=1 only in MOVE_IN.
  - Step counter advances each cycle with JAM=0. When it equals STEP_CYCLES-1, POS steps +/-1 and the counter clears.
  - JAM=1 freezes the step counter and increments the stall counter. The stall counter clears on any step.
  - Stall counter reaching TIMEOUT -> FAULTED; POS is held.
  - Commands are start triggers only; deasserting them mid-move has no effect.
  - Same-direction command mid-move: ignored. Opposite-direction command mid-move: ignored.
  - EN_RESET mid-move -> HOMING, with counters cleared.
  - EN_ALARM overrides everything -> ALARM; MOTOR_ON=0 from the next cycle.
  - Completion: on the edge where POS becomes the target (POS_MAX, or 0 for MOVE_OUT/HOMING), state -> IDLE and DONE=1 for exactly one cycle.
  - Latency: for N steps with no JAM, DONE is high N*STEP_CYCLES cycles after the command-sampling edge.
  - POS never wraps; it is saturated to 0..POS_MAX.
- FAULTED:
  - FAULT=1, MOTOR_ON=0, POS held. Other commands are ignored.
  - EN_ALARM -> ALARM; FAULT remains set.
  - EN_RESET -> HOMING; FAULT clears on that transition.
- ALARM:
  - ALARM_OUT=1, MOTOR_ON=0, POS held.
  - BUZZ starts at 0 and toggles every ALARM_DIV cycles.
  - Exit only when EN_ALARM=0 and EN_RESET=1 -> HOMING; ALARM_OUT, BUZZ and FAULT all clear.
- No DONE pulse on fault or alarm entry.

Test Plan:
- Reset: assert rst 2 cycles during a move at POS=3 -> next cycle POS=0, state IDLE, MOTOR_ON=BUSY=DONE=FAULT=ALARM_OUT=BUZZ=0.
- Insert from 0 (defaults): EN_INSERT for 1 cycle -> MOTOR_ON=1, MOTOR_DIR=1, BUSY=1; POS steps every 4 cycles; POS=10 with a single DONE pulse 40 cycles after the sampling edge; BUSY then 0.
- Boundary: EN_INSERT at POS=10 -> DONE next cycle, MOTOR_ON stays 0. EN_INSERT and EN_RELEASE together in IDLE -> FAULT=1.
- Jam: from POS=10 issue EN_RELEASE, then hold JAM=1 after the first step -> after 16 stalled cycles FAULT=1, MOTOR_ON=0, POS=9. Then EN_RESET -> FAULT=0, homing to POS=0 in 36 cycles, DONE pulse.
- Alarm mid-move: EN_ALARM at POS=5 during insert -> MOTOR_ON=0 next cycle, ALARM_OUT=1, BUZZ toggles every 2 cycles. Raising EN_RESET while EN_ALARM=1 has no effect. Then EN_ALARM=0 with EN_RESET=1 -> HOMING to 0, DONE.
- Reset abort: EN_RESET at POS=4 during MOVE_IN -> MOTOR_DIR=0 next cycle, POS descends to 0, single DONE pulse, no FAULT.

Source files
------------

// File: rtl/fsm_actuator.sv
// -----------------------------------------------------------------------------
// fsm_actuator
// Far-end responder for the fsm_module command interface. Takes the
// controller's commands and drives a stepped motor model. Position moves
// one step every STEP_CYCLES unjammed cycles. A stall that lasts TIMEOUT
// cycles latches FAULT, which goes back to the controller.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   EN_INSERT   command: move toward POS_MAX
//   EN_RELEASE  command: move toward 0
//   EN_RESET    command: clear fault/alarm, home to 0
//   EN_ALARM    command: emergency stop + alarm
//   JAM         mechanism stall indicator (blocks stepping)
//   MOTOR_ON    motor drive enable
//   MOTOR_DIR   1 = insert direction, 0 = release/home
//   POS         current position, 0..POS_MAX
//   BUSY        high in MOVE_IN, MOVE_OUT, HOMING
//   DONE        one-cycle completion pulse
//   FAULT       latched fault
//   ALARM_OUT   alarm active level
//   BUZZ        alarm tone, toggles every ALARM_DIV cycles while in ALARM
// All outputs are registered.
// -----------------------------------------------------------------------------
module fsm_actuator #(
   parameter int POS_W       = 4,
   parameter int POS_MAX     = 10,
   parameter int STEP_CYCLES = 4,
   parameter int TIMEOUT     = 16,
   parameter int ALARM_DIV   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN_INSERT,
   input  logic             EN_RELEASE,
   input  logic             EN_RESET,
   input  logic             EN_ALARM,
   input  logic             JAM,
   output logic             MOTOR_ON,
   output logic             MOTOR_DIR,
   output logic [POS_W-1:0] POS,
   output logic             BUSY,
   output logic             DONE,
   output logic             FAULT,
   output logic             ALARM_OUT,
   output logic             BUZZ
);

   localparam int SW = $clog2(STEP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(ALARM_DIV + 1);

   localparam logic [POS_W-1:0] POS_TOP    = POS_W'(POS_MAX);
   localparam logic [SW-1:0]    STEP_LAST  = SW'(STEP_CYCLES - 1);
   localparam logic [TW-1:0]    STALL_LAST = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0]    BUZZ_LAST  = BW'(ALARM_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MOVE_IN, S_MOVE_OUT, S_HOMING, S_FAULTED, S_ALARM
   } state_t;

   state_t          state;
   logic [SW-1:0]   step_cnt;
   logic [TW-1:0]   stall_cnt;
   logic [BW-1:0]   buzz_cnt;
   logic [POS_W-1:0] pos_up, pos_dn;

   assign pos_up = POS + POS_W'(1);
   assign pos_dn = POS - POS_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         POS       <= '0;
         step_cnt  <= '0;
         stall_cnt <= '0;
         buzz_cnt  <= '0;
         MOTOR_ON  <= 1'b0;
         MOTOR_DIR <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FAULT     <= 1'b0;
         ALARM_OUT <= 1'b0;
         BUZZ      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (EN_ALARM) begin
                  state     <= S_ALARM;
                  ALARM_OUT <= 1'b1;
                  BUZZ      <= 1'b0;
                  buzz_cnt  <= '0;
               end else if (EN_RESET) begin
                  // Already home: complete immediately.
                  if (POS == '0) begin
                     DONE <= 1'b1;
                  end else begin
                     state     <= S_HOMING;
                     step_cnt  <= '0;
                     stall_cnt <= '0;
                     MOTOR_ON  <= 1'b1;
                     MOTOR_DIR <= 1'b0;
                     BUSY      <= 1'b1;
                  end
               end else if (EN_INSERT && EN_RELEASE) begin
                  state <= S_FAULTED;
                  FAULT <= 1'b1;
               end else if (EN_INSERT) begin
                  if (POS == POS_TOP) begin
                     DONE <= 1'b1;
                  end else begin
                     state     <= S_MOVE_IN;
                     step_cnt  <= '0;
                     stall_cnt <= '0;
                     MOTOR_ON  <= 1'b1;
                     MOTOR_DIR <= 1'b1;
                     BUSY      <= 1'b1;
                  end
               end else if (EN_RELEASE) begin
                  if (POS == '0) begin
                     DONE <= 1'b1;
                  end else begin
                     state     <= S_MOVE_OUT;
                     step_cnt  <= '0;
                     stall_cnt <= '0;
                     MOTOR_ON  <= 1'b1;
                     MOTOR_DIR <= 1'b0;
                     BUSY      <= 1'b1;
                  end
               end
            end

            S_MOVE_IN, S_MOVE_OUT, S_HOMING: begin
               if (EN_ALARM) begin
                  state     <= S_ALARM;
                  MOTOR_ON  <= 1'b0;
                  MOTOR_DIR <= 1'b0;
                  BUSY      <= 1'b0;
                  ALARM_OUT <= 1'b1;
                  BUZZ      <= 1'b0;
                  buzz_cnt  <= '0;
               end else if (EN_RESET) begin
                  // Restart as a homing move; a reset before the first step
                  // away from 0 finds the mechanism already home.
                  step_cnt  <= '0;
                  stall_cnt <= '0;
                  MOTOR_DIR <= 1'b0;
                  if (POS == '0) begin
                     state    <= S_IDLE;
                     MOTOR_ON <= 1'b0;
                     BUSY     <= 1'b0;
                     DONE     <= 1'b1;
                  end else begin
                     state <= S_HOMING;
                  end
               end else if (JAM) begin
                  // Step counter frozen while jammed; stall counter runs.
                  if (stall_cnt == STALL_LAST) begin
                     state     <= S_FAULTED;
                     stall_cnt <= '0;
                     step_cnt  <= '0;
                     MOTOR_ON  <= 1'b0;
                     MOTOR_DIR <= 1'b0;
                     BUSY      <= 1'b0;
                     FAULT     <= 1'b1;
                  end else begin
                     stall_cnt <= stall_cnt + TW'(1);
                  end
               end else if (step_cnt == STEP_LAST) begin
                  step_cnt  <= '0;
                  stall_cnt <= '0;
                  if (state == S_MOVE_IN) begin
                     if (POS != POS_TOP) POS <= pos_up;
                     if (pos_up == POS_TOP || POS == POS_TOP) begin
                        state     <= S_IDLE;
                        MOTOR_ON  <= 1'b0;
                        MOTOR_DIR <= 1'b0;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                     end
                  end else begin
                     if (POS != '0) POS <= pos_dn;
                     if (pos_dn == '0 || POS == '0) begin
                        state    <= S_IDLE;
                        MOTOR_ON <= 1'b0;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                     end
                  end
               end else begin
                  step_cnt <= step_cnt + SW'(1);
               end
            end

            S_FAULTED: begin
               if (EN_ALARM) begin
                  // FAULT stays latched through the alarm.
                  state     <= S_ALARM;
                  ALARM_OUT <= 1'b1;
                  BUZZ      <= 1'b0;
                  buzz_cnt  <= '0;
               end else if (EN_RESET) begin
                  FAULT     <= 1'b0;
                  step_cnt  <= '0;
                  stall_cnt <= '0;
                  if (POS == '0) begin
                     state <= S_IDLE;
                     DONE  <= 1'b1;
                  end else begin
                     state     <= S_HOMING;
                     MOTOR_ON  <= 1'b1;
                     MOTOR_DIR <= 1'b0;
                     BUSY      <= 1'b1;
                  end
               end
            end

            S_ALARM: begin
               if (!EN_ALARM && EN_RESET) begin
                  ALARM_OUT <= 1'b0;
                  BUZZ      <= 1'b0;
                  FAULT     <= 1'b0;
                  buzz_cnt  <= '0;
                  step_cnt  <= '0;
                  stall_cnt <= '0;
                  if (POS == '0) begin
                     state <= S_IDLE;
                     DONE  <= 1'b1;
                  end else begin
                     state     <= S_HOMING;
                     MOTOR_ON  <= 1'b1;
                     MOTOR_DIR <= 1'b0;
                     BUSY      <= 1'b1;
                  end
               end else if (buzz_cnt == BUZZ_LAST) begin
                  buzz_cnt <= '0;
                  BUZZ     <= ~BUZZ;
               end else begin
                  buzz_cnt <= buzz_cnt + BW'(1);
               end
            end

            default: begin
               state     <= S_IDLE;
               MOTOR_ON  <= 1'b0;
               MOTOR_DIR <= 1'b0;
               BUSY      <= 1'b0;
            end
         endcase
      end
   end

endmodule
